// File: rtl/mda_motor_hbridge_driver.sv
// Multi-channel H-bridge gate driver: PWM speed control, enforced dead time on every mode change, global e-stop.
// Optional macro MDA_MOTOR_BRAKE_EN: IDLE drives BRAKE (4'b0101) instead of COAST.
module mda_motor_hbridge_driver #(
  parameter int NUM_CH = 6,
  parameter int PWM_W = 8,
  parameter int DT_W = 10,
  parameter logic [DT_W-1:0] DEAD_TIME = 10'd500
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH-1:0]         dir,
  input  logic [NUM_CH*PWM_W-1:0]   duty,
  input  logic                      estop,
  output logic [4*NUM_CH-1:0]       out,
  output logic [NUM_CH-1:0]         busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_DEAD, ST_FWD, ST_REV} state_t;

  localparam logic [3:0] FWD_CODE   = 4'b1001;
  localparam logic [3:0] REV_CODE   = 4'b0110;
  localparam logic [3:0] COAST_CODE = 4'b0000;
`ifdef MDA_MOTOR_BRAKE_EN
  localparam logic [3:0] IDLE_CODE  = 4'b0101;
`else
  localparam logic [3:0] IDLE_CODE  = 4'b0000;
`endif

  localparam logic [DT_W-1:0]  DT_LOAD = DEAD_TIME - 1'b1;
  localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}} - 1'b1;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  state_t            tgt_q [NUM_CH];
  state_t            tgt_d [NUM_CH];
  state_t            req [NUM_CH];
  logic [DT_W-1:0]   dt_q [NUM_CH];
  logic [DT_W-1:0]   dt_d [NUM_CH];
  logic [PWM_W-1:0]  duty_lat_q [NUM_CH];
  logic [PWM_W-1:0]  duty_lat_d [NUM_CH];
  logic [PWM_W-1:0]  duty_eff [NUM_CH];
  logic [NUM_CH-1:0] pwm_on;
  logic [PWM_W-1:0]  cnt_q, cnt_d;
  logic [4*NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] busy_q, busy_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    out_d  = '0;
    busy_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // The fresh duty is used on the cnt=0 cycle itself so a new value starts cleanly at a period boundary.
      duty_eff[c]   = (cnt_q == '0) ? duty[c*PWM_W +: PWM_W] : duty_lat_q[c];
      duty_lat_d[c] = duty_eff[c];
      pwm_on[c]     = (cnt_q < duty_eff[c]);
      req[c]        = !en[c] ? ST_IDLE : (dir[c] ? ST_FWD : ST_REV);

      state_d[c] = state_q[c];
      tgt_d[c]   = tgt_q[c];
      dt_d[c]    = dt_q[c];
      if (estop) begin
        state_d[c] = ST_DEAD;
        tgt_d[c]   = req[c];
        dt_d[c]    = DT_LOAD;
      end else begin
        case (state_q[c])
          ST_DEAD: begin
            if (req[c] != tgt_q[c]) begin
              tgt_d[c] = req[c];
              dt_d[c]  = DT_LOAD;
            end else if (dt_q[c] == '0) begin
              state_d[c] = tgt_q[c];
            end else begin
              dt_d[c] = dt_q[c] - 1'b1;
            end
          end
          default: begin
            if (req[c] != state_q[c]) begin
              state_d[c] = ST_DEAD;
              tgt_d[c]   = req[c];
              dt_d[c]    = DT_LOAD;
            end
          end
        endcase
      end

      busy_d[c] = (state_q[c] == ST_DEAD);
      case (state_q[c])
        ST_FWD:  out_d[4*c +: 4] = pwm_on[c] ? FWD_CODE : COAST_CODE;
        ST_REV:  out_d[4*c +: 4] = pwm_on[c] ? REV_CODE : COAST_CODE;
        ST_IDLE: out_d[4*c +: 4] = IDLE_CODE;
        default: out_d[4*c +: 4] = COAST_CODE;
      endcase
      if (estop) begin
        out_d[4*c +: 4] = COAST_CODE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      out_q  <= '0;
      busy_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]    <= ST_IDLE;
        tgt_q[c]      <= ST_IDLE;
        dt_q[c]       <= '0;
        duty_lat_q[c] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]    <= state_d[c];
        tgt_q[c]      <= tgt_d[c];
        dt_q[c]       <= dt_d[c];
        duty_lat_q[c] <= duty_lat_d[c];
      end
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule
